// File: rtl/nand_page_reader.sv
// nand_page_reader: source-side page read engine. Issues READ (00h) plus
// three address cycles to flash A, waits out tWB and the R/B# busy period,
// then pulses RE# once per byte and streams the page out on a valid/ready
// interface with back-pressure. Every output is driven straight from a flop.
`timescale 1ns/1ps

module nand_page_reader #(
  parameter int          PAGE_BYTES = 512,
  parameter int          WB_WAIT    = 4,
  parameter logic [7:0]  CMD_READ   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active low
  input  logic       start,
  input  logic [8:0] page,
  output logic       busy,
  output logic       done,
  output logic       f_cle,
  output logic       f_ale,
  output logic       f_wen,
  output logic       f_ren,
  input  logic       f_rb,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam int WBW = (WB_WAIT > 1) ? $clog2(WB_WAIT) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD_LO,    // CLE high, WE# low
    ST_CMD_HI,    // WE# high, command byte still on the bus
    ST_ADDR_LO,   // ALE high, WE# low
    ST_ADDR_HI,   // WE# high, address byte still on the bus
    ST_WAIT_WB,   // give the flash tWB to pull R/B# low
    ST_WAIT_RB,   // wait for the synchronised R/B# to report ready
    ST_READ_LO,   // RE# low for one cycle
    ST_READ_HI,   // RE# high, byte presented downstream
    ST_DONE
  } state_e;

  state_e         state_q,     state_d;
  logic [8:0]     page_q,      page_d;
  logic [1:0]     addr_idx_q,  addr_idx_d;
  logic [WBW-1:0] wb_cnt_q,    wb_cnt_d;
  logic [9:0]     col_q,       col_d;
  logic           rb_s1_q,     rb_s2_q;
  logic           busy_q,      busy_d;
  logic           done_q,      done_d;
  logic           cle_q,       cle_d;
  logic           ale_q,       ale_d;
  logic           wen_q,       wen_d;
  logic           ren_q,       ren_d;
  logic [7:0]     io_out_q,    io_out_d;
  logic           io_oe_q,     io_oe_d;
  logic [7:0]     out_data_q,  out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q,  out_last_d;

  // Next-state and next-output decode for the whole read sequence.
  always_comb begin
    // NOTE: every _d starts as its _q (done as 0) so no path leaves a signal
    // unassigned; that is what keeps this block from inferring latches.
    state_d     = state_q;
    page_d      = page_q;
    addr_idx_d  = addr_idx_q;
    wb_cnt_d    = wb_cnt_q;
    col_d       = col_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cle_d       = cle_q;
    ale_d       = ale_q;
    wen_d       = wen_q;
    ren_d       = ren_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          page_d   = page;
          col_d    = '0;
          busy_d   = 1'b1;
          cle_d    = 1'b1;
          io_oe_d  = 1'b1;
          io_out_d = CMD_READ;
          wen_d    = 1'b0;
          state_d  = ST_CMD_LO;
        end
      end

      ST_CMD_LO: begin
        wen_d   = 1'b1;
        state_d = ST_CMD_HI;
      end

      ST_CMD_HI: begin
        cle_d      = 1'b0;
        ale_d      = 1'b1;
        io_out_d   = 8'h00;           // column low byte, always 0
        wen_d      = 1'b0;
        addr_idx_d = 2'd0;
        state_d    = ST_ADDR_LO;
      end

      ST_ADDR_LO: begin
        wen_d   = 1'b1;
        state_d = ST_ADDR_HI;
      end

      ST_ADDR_HI: begin
        if (addr_idx_q == 2'd2) begin
          ale_d    = 1'b0;
          io_oe_d  = 1'b0;
          io_out_d = 8'h00;
          wb_cnt_d = '0;
          state_d  = ST_WAIT_WB;
        end else begin
          addr_idx_d = addr_idx_q + 2'd1;
          io_out_d   = (addr_idx_q == 2'd0) ? page_q[7:0] : {7'b0, page_q[8]};
          wen_d      = 1'b0;
          state_d    = ST_ADDR_LO;
        end
      end

      ST_WAIT_WB: begin
        if (wb_cnt_q == WBW'(WB_WAIT - 1)) begin
          state_d = ST_WAIT_RB;
        end else begin
          wb_cnt_d = wb_cnt_q + WBW'(1);
        end
      end

      ST_WAIT_RB: begin
        if (rb_s2_q) begin
          ren_d   = 1'b0;
          state_d = ST_READ_LO;
        end
      end

      ST_READ_LO: begin
        out_data_d  = io_in;
        out_valid_d = 1'b1;
        out_last_d  = (col_q == 10'(PAGE_BYTES - 1));
        ren_d       = 1'b1;
        col_d       = col_q + 10'd1;
        state_d     = ST_READ_HI;
      end

      ST_READ_HI: begin
        // Hold the byte and keep RE# high until the consumer takes it.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            ren_d   = 1'b0;
            state_d = ST_READ_LO;
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, R/B# synchroniser and all output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every flop, including the pin drivers, is reset so that a reset
      // mid-read parks the flash bus at its idle levels immediately.
      state_q     <= ST_IDLE;
      page_q      <= '0;
      addr_idx_q  <= '0;
      wb_cnt_q    <= '0;
      col_q       <= '0;
      rb_s1_q     <= 1'b0;
      rb_s2_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      wen_q       <= 1'b1;
      ren_q       <= 1'b1;
      io_out_q    <= '0;
      io_oe_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      page_q      <= page_d;
      addr_idx_q  <= addr_idx_d;
      wb_cnt_q    <= wb_cnt_d;
      col_q       <= col_d;
      rb_s1_q     <= f_rb;
      rb_s2_q     <= rb_s1_q;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign f_cle     = cle_q;
  assign f_ale     = ale_q;
  assign f_wen     = wen_q;
  assign f_ren     = ren_q;
  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_nand_page_reader.sv
// Bench for nand_page_reader: a behavioural flash A (command/address log,
// busy timer, page memory as a formula) plus a byte-stream scoreboard.
`timescale 1ns/1ps

module tb_nand_page_reader;

  localparam int PAGE_BYTES = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] page = '0;
  logic       busy, done, f_cle, f_ale, f_wen, f_ren;
  logic       f_rb = 1'b1;
  logic [7:0] io_in = '0;
  logic [7:0] io_out;
  logic       io_oe;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;

  always #10 clk = ~clk;

  nand_page_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .page      (page),
    .busy      (busy),
    .done      (done),
    .f_cle     (f_cle),
    .f_ale     (f_ale),
    .f_wen     (f_wen),
    .f_ren     (f_ren),
    .f_rb      (f_rb),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash A page memory, byte address = page*512 + column.
  function automatic logic [7:0] mem_byte(input int addr);
    return 8'(addr * 73 + (addr >> 9) * 151 + 17);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- flash A model ----------------
  logic [10:0] wlog[$];          // {io_oe, cle, ale, byte} at each WE# rise
  logic [7:0]  addr_b[3];
  int          addr_n = 0;
  int          fl_page = 0;
  int          fl_col = 0;
  bit          busy_req = 1'b0;
  int          busy_cycles = 20;
  int          busy_left = 0;
  int          rb_rise_cyc = -1;

  always @(posedge f_wen) begin
    if (rst) begin
      wlog.push_back({io_oe, f_cle, f_ale, io_out});
      if (f_cle) begin
        addr_n = 0;
      end else if (f_ale && addr_n < 3) begin
        addr_b[addr_n] = io_out;
        addr_n++;
        if (addr_n == 3) begin
          fl_page  = int'({addr_b[2][0], addr_b[1]});
          fl_col   = 0;
          busy_req = 1'b1;
        end
      end
    end
  end

  always @(negedge f_ren) begin
    if (rst) begin
      io_in = mem_byte(fl_page * PAGE_BYTES + fl_col);
      fl_col++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (busy_req) begin
      busy_req  = 1'b0;
      f_rb      = 1'b0;
      busy_left = busy_cycles;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        f_rb        = 1'b1;
        rb_rise_cyc = cyc;
      end
    end
  end

  // ---------------- consumer ----------------
  bit bp_mode = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // ---------------- scoreboard / compare ----------------
  logic [8:0] exp_q[$];          // {last, data} per expected byte
  logic [8:0] exp_e;
  int         page_bytes_seen = 0;
  int         done_count = 0;
  int         re_falls = 0;
  int         first_re_cyc = -1;
  int         last_hs_cyc = -1;
  bit         chk_interval = 1'b0;
  bit         prev_pend = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic       prev_ren = 1'b1;
  logic [7:0] first_byte = '0;
  logic [7:0] last_byte = '0;
  logic [7:0] cap[PAGE_BYTES];
  logic [7:0] ref_stream[PAGE_BYTES];

  always @(negedge clk) begin
    if (!rst) begin
      prev_pend   = 1'b0;
      prev_ren    = 1'b1;
      last_hs_cyc = -1;
    end else begin
      check("cle_ale_exclusive", longint'(f_cle & f_ale), 0);
      check("wen_ren_exclusive", longint'(!f_wen && !f_ren), 0);
      if (prev_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data",  out_data,  prev_data);
        check("hold_last",  out_last,  prev_last);
        check("hold_ren",   f_ren,     1);
      end
      if (prev_ren && !f_ren) begin
        re_falls++;
        if (first_re_cyc < 0) first_re_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        check("byte_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("byte_data", out_data, exp_e[7:0]);
          check("byte_last", out_last, exp_e[8]);
        end
        if (page_bytes_seen == 0) first_byte = out_data;
        if (page_bytes_seen < PAGE_BYTES) cap[page_bytes_seen] = out_data;
        if (out_last) last_byte = out_data;
        if (chk_interval && last_hs_cyc >= 0) check("byte_interval", cyc - last_hs_cyc, 2);
        last_hs_cyc = out_last ? -1 : cyc;
        page_bytes_seen++;
      end
      if (done) done_count++;
      prev_pend = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      prev_ren  = f_ren;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [8:0] pg);
    @(posedge clk);
    #1;
    start = 1'b1;
    page  = pg;
    for (int i = 0; i < PAGE_BYTES; i++)
      exp_q.push_back({(i == PAGE_BYTES - 1), mem_byte(int'(pg) * PAGE_BYTES + i)});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int target;
    int n;
    target = done_count + 1;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, longint'(done_count >= target), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0;
  int n;
  int mism;

  initial begin
    // ---- reset values ----
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_f_cle",     f_cle,     0);
    check("rst_f_ale",     f_ale,     0);
    check("rst_f_wen",     f_wen,     1);
    check("rst_f_ren",     f_ren,     1);
    check("rst_io_oe",     io_oe,     0);
    check("rst_io_out",    io_out,    0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last",  out_last,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // ---- command / address sequence, page 1A5 ----
    wlog.delete();
    d0 = done_count;
    do_start(9'h1A5);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    wait_done("done_page_1a5", 3000);
    check("we_count_1a5", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("cle_byte",   wlog[0], {1'b1, 1'b1, 1'b0, 8'h00});
      check("ale_byte0",  wlog[1], {1'b1, 1'b0, 1'b1, 8'h00});
      check("ale_byte1",  wlog[2], {1'b1, 1'b0, 1'b1, 8'hA5});
      check("ale_byte2",  wlog[3], {1'b1, 1'b0, 1'b1, 8'h01});
    end
    repeat (50) @(negedge clk);
    check("no_extra_we",    wlog.size(), 4);
    check("done_once_1a5",  done_count - d0, 1);
    check("busy_low_after", busy, 0);
    check("queue_drained_1a5", exp_q.size(), 0);

    // ---- full page 3, ready tied high ----
    chk_interval    = 1'b1;
    re_falls        = 0;
    page_bytes_seen = 0;
    d0 = done_count;
    do_start(9'd3);
    wait_done("done_page3", 3000);
    repeat (5) @(negedge clk);
    chk_interval = 1'b0;
    check("page3_bytes",      page_bytes_seen, 512);
    check("page3_re_pulses",  re_falls, 512);
    check("page3_done_once",  done_count - d0, 1);
    check("page3_first_byte", first_byte, 8'hD6);   // fa.Mem[1536]
    check("page3_last_byte",  last_byte,  8'h8D);   // fa.Mem[2047]
    for (int i = 0; i < PAGE_BYTES; i++) ref_stream[i] = cap[i];

    // ---- back-pressure, same page ----
    bp_mode         = 1'b1;
    re_falls        = 0;
    page_bytes_seen = 0;
    do_start(9'd3);
    wait_done("done_page3_bp", 20000);
    bp_mode = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_bytes",     page_bytes_seen, 512);
    check("bp_re_pulses", re_falls, 512);
    mism = 0;
    for (int i = 0; i < PAGE_BYTES; i++) if (cap[i] !== ref_stream[i]) mism++;
    check("bp_stream_equal", mism, 0);
    check("bp_queue_drained", exp_q.size(), 0);

    // ---- long busy period ----
    busy_cycles  = 500;
    re_falls     = 0;
    first_re_cyc = -1;
    rb_rise_cyc  = -1;
    do_start(9'd7);
    n = 0;
    while (rb_rise_cyc < 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rb_rose", longint'(rb_rise_cyc >= 0), 1);
    check("no_re_while_busy", re_falls, 0);
    wait_done("done_page7", 3000);
    // two synchroniser stages, then the registered RE# falls on the next edge
    check("rb_to_re_cycles", first_re_cyc - rb_rise_cyc, 3);
    busy_cycles = 20;

    // ---- page boundaries, ignored start ----
    wlog.delete();
    d0 = done_count;
    do_start(9'd0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    page  = 9'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_held_ignored_start", busy, 1);
    wait_done("done_page0", 3000);
    check("page0_we_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("page0_addr1", wlog[2], {1'b1, 1'b0, 1'b1, 8'h00});
      check("page0_addr2", wlog[3], {1'b1, 1'b0, 1'b1, 8'h00});
    end
    wlog.delete();
    do_start(9'd511);
    wait_done("done_page511", 3000);
    repeat (30) @(negedge clk);
    check("page511_we_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("page511_addr1", wlog[2], {1'b1, 1'b0, 1'b1, 8'hFF});
      check("page511_addr2", wlog[3], {1'b1, 1'b0, 1'b1, 8'h01});
    end
    check("boundary_done_count", done_count - d0, 2);
    check("boundary_queue_drained", exp_q.size(), 0);

    // ---- reset in the middle of byte 100 ----
    page_bytes_seen = 0;
    do_start(9'd2);
    n = 0;
    while (page_bytes_seen < 100 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte100", longint'(page_bytes_seen >= 100), 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_f_ren",     f_ren,     1);
    check("midrst_f_wen",     f_wen,     1);
    check("midrst_io_oe",     io_oe,     0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy",      busy,      0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    page_bytes_seen = 0;
    re_falls        = 0;
    do_start(9'd0);
    wait_done("done_after_reset", 3000);
    repeat (5) @(negedge clk);
    check("after_reset_bytes",      page_bytes_seen, 512);
    check("after_reset_first_byte", first_byte, 8'h11);   // fa.Mem[0]
    check("after_reset_re_pulses",  re_falls, 512);
    check("after_reset_queue",      exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_page_reader.md
Name: nand_page_reader

Overview:
- Source-side read engine of the NFC: drives the flash A pins to fetch one 512-byte page and streams its bytes, in order, to the downstream page-program engine that writes flash B.
- Issues read command 00h and three address cycles, waits out the flash busy period, then pulses RE# once per byte.
- Exposes the bytes on a valid/ready stream with back-pressure.
- NFC top ties the split IO bus (io_out/io_oe/io_in) to the F_IO_A inout.

Parameters:
- PAGE_BYTES, 512, bytes read per page; column always starts at 0.
- WB_WAIT, 4, cycles waited after the last address cycle before R/B# is sampled (covers tWB).
- CMD_READ, 8'h00, read command byte.

Ports:
- clk  in  1  system clock, 20 ns.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- page  in  9  page number; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte handshake.
- f_cle  out  1  command latch enable.
- f_ale  out  1  address latch enable.
- f_wen  out  1  WE#, active low.
- f_ren  out  1  RE#, active low.
- f_rb  in  1  ready/busy#; 0 = busy.
- io_in  in  8  flash IO as read.
- io_out  out  8  flash IO drive value.
- io_oe  out  1  drive enable for io_out.
- out_data  out  8  streamed page byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer ready.
- out_last  out  1  high with the byte at column PAGE_BYTES-1.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - Pins: f_cle=0, f_ale=0, f_wen=1, f_ren=1, io_oe=0, io_out=0.
  - Stream and status: out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - Counters cleared.
  - Reset mid-operation aborts immediately; no partial stream resumes.
- IDLE: when start=1, latch page and go to CMD. start is ignored while busy=1.
- CMD, 2 cycles:
  - Cycle 0: f_cle=1, io_oe=1, io_out=CMD_READ, f_wen=0.
  - Cycle 1: f_wen=1; CLE and IO held, so data is stable at the WE# rising edge.
- ADDR, 3 bytes x 2 cycles, same WE# low/high pattern with f_ale=1 and f_cle=0:
  - Byte 0: 8'h00 (column).
  - Byte 1: page[7:0].
  - Byte 2: {7'b0, page[8]}.
  - After byte 2: f_ale=0, io_oe=0.
- WAIT_WB: count WB_WAIT cycles, then go to WAIT_RB.
- WAIT_RB: stay while f_rb=0. f_rb is double-flopped before use (2-cycle sampling latency). Proceed to READ_LO when the synchronised f_rb=1.
- READ_LO: f_ren=0 for exactly 1 cycle.
  - On the edge leaving READ_LO: out_data<=io_in, out_valid<=1, out_last<=(col==PAGE_BYTES-1), f_ren<=1, col++.
- READ_HI: f_ren=1; out_valid held until out_valid&out_ready.
  - Handshake and not last: next cycle READ_LO. Steady state with out_ready=1 is 1 byte per 2 cycles.
  - Handshake and last: out_valid<=0, go to DONE.
  - No handshake: remain in READ_HI with out_data stable and RE# high. No further RE# pulse while a byte is pending.
- DONE: done=1 for 1 cycle, busy<=0, return to IDLE. out_last clears with out_valid.
- The column counter is 10 bits wide so it reaches 512 without wrap; it restarts at 0 on each start.
- f_cle and f_ale are never high simultaneously; f_wen and f_ren are never low simultaneously.
- All outputs are registered.
- Latency from accepted start to the first out_valid = 2 (CMD) + 6 (ADDR) + WB_WAIT + busy time + 2 (sync) + 1 (READ_LO).

Test Plan:
- Reset mid-read: assert rst during byte 100 → all pins at idle values (f_ren=1, f_wen=1, io_oe=0) within the same cycle; out_valid=0. A new start with page=0 then streams from byte 0.
- Command/address sequence, start with page=9'h1A5, checked against the flash_a model:
  - CLE cycle carries 00h.
  - ALE bytes are 00h, A5h, 01h, each stable at the WE# rising edge.
  - No WE# pulses occur after these.
- Full page, page=3, out_ready tied 1:
  - 512 bytes equal fa.Mem[1536..2047] in order.
  - out_last only on byte 511.
  - done pulses once.
  - Byte interval is 2 cycles.
- Back-pressure: out_ready random at 30% duty → the byte stream is identical to the full-page run, and the count of RE# low pulses equals 512 exactly.
- Busy hold: the model holds f_rb=0 for 500 cycles → no RE# pulse until 2 cycles after f_rb rises.
- Page boundaries: page=0 then page=511 back-to-back, with start asserted during busy also checked:
  - The third address byte is 00h for page 0 and 01h for page 511.
  - A start asserted while busy is ignored.
  - Both pages match memory.
